div_repeated_sub: RTL and testbench

- Sequential unsigned integer divider using repeated subtraction; the inverse of the repeated-addition multiplier.
- Shares that multiplier's usage model: single `start` pulse, operands presented one per cycle on a shared `data_in` bus (dividend, then divisor), `done` level on completion.
- Datapath and controller live in one module.
- Used wherever the design needs a low-area divide and latency of up to 2^W cycles is acceptable.

---
 rtl/div_repeated_sub_if.sv | 23 ++
 rtl/div_repeated_sub.sv | 94 +++++++++
 tb/tb_div_repeated_sub.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/div_repeated_sub_if.sv
// Operand/result bundle for the repeated-subtraction divider.
// The master drives start and data_in; the slave returns the result and status.
interface div_repeated_sub_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_by_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/div_repeated_sub.sv
// Sequential unsigned divider: subtracts the divisor from the dividend until it no
// longer fits, counting subtractions; operands arrive one per cycle on data_in.
module div_repeated_sub #(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst,
  div_repeated_sub_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_DONE
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_q;
  logic         r_dz;
  logic         r_done;
  logic         r_busy;

  assign bus.quotient    = r_q;
  assign bus.remainder   = r_a;
  assign bus.div_by_zero = r_dz;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;

  // done/busy are registered alongside the state so they switch on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: every register in this block uses <= so all updates see pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_LOAD_A;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD_A: begin
          r_a     <= bus.data_in;
          r_dz    <= 1'b0;
          r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_b     <= bus.data_in;
          r_q     <= '0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          if (r_b == '0) begin
            r_dz    <= 1'b1;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_a >= r_b) begin
            // Guarded by the compare, so this never wraps and Q stays within W bits.
            r_a <= r_a - r_b;
            r_q <= r_q + 1'b1;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.start) begin
            r_state <= S_LOAD_A;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_repeated_sub.sv
// Directed bench for div_repeated_sub: hand-computed quotient, remainder, flags
// and done latency for boundary operands, mid-operation reset and restarts.
module tb_div_repeated_sub;
  localparam int W      = 16;
  localparam int BUDGET = 70000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  div_repeated_sub_if #(.W(W)) bus ();

  div_repeated_sub #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Waits for done within the cycle budget; returns cycles counted from the edge after E2.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full division from IDLE or DONE; poke raises start while the divider is busy.
  task automatic div_op(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input logic exp_dz, input int exp_lat, input bit poke);
    int n;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = '0;
    @(negedge clk);
    check({tag, "_busy_e0"}, bus.busy, 1);
    check({tag, "_done_drop"}, bus.done, 0);
    bus.start   = poke;
    bus.data_in = dvd;
    @(negedge clk);
    bus.data_in = dvs;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = '0;
    wait_done(n);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_quotient"}, bus.quotient, exp_q);
    check({tag, "_remainder"}, bus.remainder, exp_r);
    check({tag, "_dz"}, bus.div_by_zero, exp_dz);
    check({tag, "_busy_done"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_dz", bus.div_by_zero, 0);
    rst = 1'b0;

    div_op("basic_17_5",    16'd17,    16'd5,     16'd3,     16'd2,  1'b0, 4,     1'b0);
    div_op("lt_3_5",        16'd3,     16'd5,     16'd0,     16'd3,  1'b0, 1,     1'b0);
    div_op("dz_10_0",       16'd10,    16'd0,     16'd0,     16'd10, 1'b1, 1,     1'b0);
    div_op("after_dz_12_4", 16'd12,    16'd4,     16'd3,     16'd0,  1'b0, 4,     1'b0);
    div_op("dz_0_0",        16'd0,     16'd0,     16'd0,     16'd0,  1'b1, 1,     1'b0);
    div_op("zero_0_7",      16'd0,     16'd7,     16'd0,     16'd0,  1'b0, 1,     1'b0);
    div_op("eq_max",        16'hFFFF,  16'hFFFF,  16'd1,     16'd0,  1'b0, 2,     1'b0);
    div_op("max_by_1",      16'hFFFF,  16'd1,     16'hFFFF,  16'd0,  1'b0, 65536, 1'b0);

    // Reset while in CALC with ten subtractions done.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = 16'd100;
    @(negedge clk);
    bus.data_in = 16'd3;
    @(negedge clk);
    bus.data_in = '0;
    repeat (10) @(negedge clk);
    check("mid_q10", bus.quotient, 10);
    check("mid_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_quotient", bus.quotient, 0);
    check("mid_rst_remainder", bus.remainder, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_dz", bus.div_by_zero, 0);
    @(negedge clk);
    check("mid_idle_hold", bus.busy, 0);

    div_op("post_rst_7_2",  16'd7,     16'd2,     16'd3,     16'd1,  1'b0, 4,     1'b0);
    div_op("poke_20_3",     16'd20,    16'd3,     16'd6,     16'd2,  1'b0, 7,     1'b1);

    // start held high: DONE immediately relaunches, operands follow each time.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.data_in = 16'd9;
    @(negedge clk);
    bus.data_in = 16'd2;
    @(negedge clk);
    bus.data_in = '0;
    wait_done(n);
    check("held1_latency", n, 5);
    check("held1_quotient", bus.quotient, 4);
    check("held1_remainder", bus.remainder, 1);
    @(negedge clk);
    check("held2_done_drop", bus.done, 0);
    bus.data_in = 16'd50;
    @(negedge clk);
    bus.data_in = 16'd7;
    @(negedge clk);
    bus.data_in = '0;
    bus.start   = 1'b0;
    wait_done(n);
    check("held2_latency", n, 8);
    check("held2_quotient", bus.quotient, 7);
    check("held2_remainder", bus.remainder, 1);
    repeat (2) @(negedge clk);
    check("held2_stays_done", bus.done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
